top_8bit_alu: RTL and testbench

TOP_8BIT_ALU -- requirements
Module: top_8bit_alu

---
 rtl/top_8bit_alu.sv | 86 ++++++++
 tb/tb_top_8bit_alu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/top_8bit_alu.sv
// 8-bit operand registers feeding a combinational add/sub/mul/div unit
// whose 16-bit result and status flag are registered every clock.
module top_8bit_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  inA,
    input  logic [7:0]  inB,
    input  logic        btnLoadA,
    input  logic        btnLoadB,
    input  logic [1:0]  op,
    output logic [15:0] led_out,
    output logic        flag_out
);

    logic [7:0]  regA_out;
    logic [7:0]  regB_out;
    logic [15:0] alu_res;
    logic        alu_flag;
    logic [8:0]  sum;
    logic [8:0]  diff;
    logic [15:0] prod;
    logic [7:0]  divisor;
    logic [7:0]  quot;
    logic [7:0]  rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regA_out <= 8'h00;
            regB_out <= 8'h00;
        end else begin
            if (btnLoadA) regA_out <= inA;
            if (btnLoadB) regB_out <= inB;
        end
    end

    // Divisor forced nonzero so the divider never sees 0; result muxed away.
    assign divisor = (regB_out == 8'h00) ? 8'h01 : regB_out;
    assign sum     = {1'b0, regA_out} + {1'b0, regB_out};
    assign diff    = {1'b0, regA_out} - {1'b0, regB_out};
    assign prod    = {8'h00, regA_out} * {8'h00, regB_out};
    assign quot    = regA_out / divisor;
    assign rem     = regA_out % divisor;

    always_comb begin
        alu_res  = 16'h0000;
        alu_flag = 1'b0;
        unique case (op)
            2'b00: begin
                alu_res  = {7'b0, sum};
                alu_flag = sum[8];
            end
            2'b01: begin
                alu_res  = {8'h00, diff[7:0]};
                alu_flag = diff[8];
            end
            2'b10: begin
                alu_res  = prod;
                alu_flag = |prod[15:8];
            end
            2'b11: begin
                if (regB_out == 8'h00) begin
                    alu_res  = 16'h0000;
                    alu_flag = 1'b1;
                end else begin
                    alu_res  = {rem, quot};
                    alu_flag = 1'b0;
                end
            end
            default: begin
                alu_res  = 16'h0000;
                alu_flag = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out  <= 16'h0000;
            flag_out <= 1'b0;
        end else begin
            led_out  <= alu_res;
            flag_out <= alu_flag;
        end
    end

endmodule

// File: tb/tb_top_8bit_alu.sv
// Randomized and directed checks of top_8bit_alu against an arithmetic model.
module tb_top_8bit_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  inA;
    logic [7:0]  inB;
    logic        btnLoadA;
    logic        btnLoadB;
    logic [1:0]  op;
    logic [15:0] led_out;
    logic        flag_out;

    int n_cmp = 0;
    int n_err = 0;
    int ma = 0;
    int mb = 0;

    top_8bit_alu dut (
        .clk(clk), .rst(rst), .inA(inA), .inB(inB),
        .btnLoadA(btnLoadA), .btnLoadB(btnLoadB), .op(op),
        .led_out(led_out), .flag_out(flag_out)
    );

    always #5 clk = ~clk;

    function automatic void model(input int a, input int b, input int o,
                                  output int res, output int flg);
        case (o)
            0: begin res = a + b; flg = (a + b > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; flg = (a < b) ? 1 : 0; end
            2: begin res = a * b; flg = (a * b > 255) ? 1 : 0; end
            default: begin
                if (b == 0) begin res = 0; flg = 1; end
                else begin res = (a % b) * 256 + a / b; flg = 0; end
            end
        endcase
    endfunction

    // Load both operands, scramble inputs, then sample after result edge.
    task automatic run_op(input int a, input int b, input int o,
                          input string name);
        int er, ef;
        @(negedge clk);
        inA = 8'(a); inB = 8'(b); op = 2'(o);
        btnLoadA = 1'b1; btnLoadB = 1'b1;
        @(negedge clk);
        btnLoadA = 1'b0; btnLoadB = 1'b0;
        inA = 8'($urandom); inB = 8'($urandom);
        @(negedge clk);
        ma = a; mb = b;
        model(a, b, o, er, ef);
        n_cmp++;
        if (led_out !== 16'(er) || flag_out !== 1'(ef)) begin
            n_err++;
            $display("FAIL %s: got led=%h flag=%b, expected led=%h flag=%0d",
                     name, led_out, flag_out, 16'(er), ef);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; inA = 0; inB = 0; op = 0;
        btnLoadA = 0; btnLoadB = 0;
        #12;
        n_cmp++;
        if (led_out !== 16'h0 || flag_out !== 1'b0 ||
            dut.regA_out !== 8'h0 || dut.regB_out !== 8'h0) begin
            n_err++;
            $display("FAIL reset: led=%h flag=%b A=%h B=%h, expected zeros",
                     led_out, flag_out, dut.regA_out, dut.regB_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (led_out !== 16'h0 || flag_out !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: led=%h flag=%b, expected 0000/0",
                     led_out, flag_out);
        end
    endtask

    task automatic test_directed();
        run_op(10, 9, 0, "add_10_9");
        n_cmp++;
        if (led_out !== 16'h0013) begin
            n_err++;
            $display("FAIL add_const: got %h, expected 0013", led_out);
        end
        run_op(2, 7, 1, "sub_borrow");
        run_op(200, 100, 0, "add_carry");
        n_cmp++;
        if (led_out !== 16'h012C || flag_out !== 1'b1) begin
            n_err++;
            $display("FAIL add_carry_const: got %h/%b, expected 012c/1",
                     led_out, flag_out);
        end
        run_op(15, 10, 2, "mul_small");
        run_op(255, 255, 2, "mul_max");
        n_cmp++;
        if (led_out !== 16'hFE01 || flag_out !== 1'b1) begin
            n_err++;
            $display("FAIL mul_max_const: got %h/%b, expected fe01/1",
                     led_out, flag_out);
        end
        run_op(100, 3, 3, "div_100_3");
        n_cmp++;
        if (led_out !== 16'h0121 || flag_out !== 1'b0) begin
            n_err++;
            $display("FAIL div_const: got %h/%b, expected 0121/0",
                     led_out, flag_out);
        end
        run_op(20, 0, 3, "div_zero");
        run_op(0, 0, 3, "div_zero_zero");
        run_op(5, 5, 1, "sub_equal");
    endtask

    task automatic test_op_change();
        int er, ef;
        for (int o = 0; o < 4; o++) begin
            @(negedge clk);
            op = 2'(o);
            inA = 8'($urandom); inB = 8'($urandom);
            @(negedge clk);
            model(ma, mb, o, er, ef);
            n_cmp++;
            if (led_out !== 16'(er) || flag_out !== 1'(ef)) begin
                n_err++;
                $display("FAIL op_change %0d: got %h/%b, expected %h/%0d",
                         o, led_out, flag_out, 16'(er), ef);
            end
        end
    endtask

    task automatic test_single_load();
        int er, ef;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            btnLoadA = 1'($urandom);
            btnLoadB = 1'($urandom);
            inA = 8'($urandom);
            inB = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            op = 2'($urandom);
            if (btnLoadA) ma = inA;
            if (btnLoadB) mb = inB;
            @(negedge clk);
            btnLoadA = 1'b0; btnLoadB = 1'b0;
            @(negedge clk);
            model(ma, mb, op, er, ef);
            n_cmp++;
            if (led_out !== 16'(er) || flag_out !== 1'(ef) ||
                dut.regA_out !== 8'(ma) || dut.regB_out !== 8'(mb)) begin
                n_err++;
                $display("FAIL single_load %0d: got %h/%b A=%h B=%h, expected %h/%0d A=%h B=%h",
                         i, led_out, flag_out, dut.regA_out, dut.regB_out,
                         16'(er), ef, 8'(ma), 8'(mb));
            end
        end
    endtask

    task automatic test_random();
        int a, b, o;
        for (int i = 0; i < 150; i++) begin
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            o = $urandom_range(0, 3);
            run_op(a, b, o, "random");
        end
    endtask

    task automatic test_async_reset();
        run_op(255, 255, 2, "pre_reset");
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (led_out !== 16'h0 || flag_out !== 1'b0 ||
            dut.regA_out !== 8'h0 || dut.regB_out !== 8'h0) begin
            n_err++;
            $display("FAIL async_reset: led=%h flag=%b A=%h B=%h, expected zeros",
                     led_out, flag_out, dut.regA_out, dut.regB_out);
        end
        ma = 0; mb = 0;
        op = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (led_out !== 16'h0 || flag_out !== 1'b0) begin
            n_err++;
            $display("FAIL resume: led=%h flag=%b, expected 0000/0",
                     led_out, flag_out);
        end
    endtask

    task automatic test_both_load();
        @(negedge clk);
        inA = 8'h5A; inB = 8'hC3;
        btnLoadA = 1'b1; btnLoadB = 1'b1;
        @(negedge clk);
        btnLoadA = 1'b0; btnLoadB = 1'b0;
        n_cmp++;
        if (dut.regA_out !== 8'h5A || dut.regB_out !== 8'hC3) begin
            n_err++;
            $display("FAIL both_load: A=%h B=%h, expected 5a c3",
                     dut.regA_out, dut.regB_out);
        end
        ma = 8'h5A; mb = 8'hC3;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_op_change();
        test_single_load();
        test_random();
        test_async_reset();
        test_both_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
